// File: rtl/route_compute_unit.sv
// route_compute_unit
//   Sequential routing-decision unit for one Phoenix router. A header
//   destination is latched in IDLE, a one-hot output port is chosen by
//   dimension-order routing (XY or YX) in CALC, the unit then waits for that
//   port to be free and holds the grant under a valid/ack handshake.
//   A wait that runs for TIMEOUT cycles ends with a one-cycle route_fail.
//
//   Optional feature: define FAULT_DETOUR_EN to let a faulty primary port be
//   replaced by the productive port on the other axis. Without it,
//   fault_mask_i is ignored.
//
// Ports
//   clock_i       rising-edge clock
//   reset_i       asynchronous active-high reset
//   req_i         header valid, sampled only in IDLE
//   dest_i        header destination {X,Y}
//   port_busy_i   per-port "currently allocated"
//   fault_mask_i  per-port "faulty" (detour build only)
//   ack_i         switch control accepted the grant
//   out_port_o    one-hot granted port (zero unless route_valid_o)
//   route_valid_o grant pending, held until ack_i
//   route_fail_o  one-cycle pulse on timeout / no usable port
//   busy_o        high in every state except IDLE
module route_compute_unit #(
    parameter int                ADDR_W     = 16,
    parameter int                COORD_W    = ADDR_W / 2,
    parameter int                NPORT      = 5,
    parameter logic [ADDR_W-1:0] LOCAL_ADDR = '0,
    parameter int                YX_MODE    = 0,
    parameter int                TIMEOUT    = 255
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] dest_i,
    input  logic [NPORT-1:0]  port_busy_i,
    input  logic [NPORT-1:0]  fault_mask_i,
    input  logic              ack_i,
    output logic [NPORT-1:0]  out_port_o,
    output logic              route_valid_o,
    output logic              route_fail_o,
    output logic              busy_o
);
    localparam int P_E = 0;
    localparam int P_W = 1;
    localparam int P_N = 2;
    localparam int P_S = 3;
    localparam int P_L = 4;

    localparam int              CW       = $clog2(TIMEOUT + 1);
    // Failing on the last busy cycle makes exactly TIMEOUT busy WAIT cycles.
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [COORD_W-1:0] LX = LOCAL_ADDR[ADDR_W-1 -: COORD_W];
    localparam logic [COORD_W-1:0] LY = LOCAL_ADDR[COORD_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WAIT, S_GRANT} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] dest_q;
    logic [NPORT-1:0]  cand_q;
    logic [CW-1:0]     cnt_q;
    logic [NPORT-1:0]  out_port_q;
    logic              route_valid_q;
    logic              route_fail_q;
    logic              busy_q;

    logic [COORD_W-1:0] dx, dy;
    logic [NPORT-1:0]   px, py, prim, alt, sel, wait_port_d;
    logic               sel_ok;

    assign dx = dest_q[ADDR_W-1 -: COORD_W];
    assign dy = dest_q[COORD_W-1:0];

    // Port selection from the latched destination.
    always_comb begin
        px = '0;
        py = '0;
        if (dx > LX)      px[P_E] = 1'b1;
        else if (dx < LX) px[P_W] = 1'b1;
        if (dy > LY)      py[P_N] = 1'b1;
        else if (dy < LY) py[P_S] = 1'b1;
        // alt is the productive port on the non-primary axis (zero if none).
        if (YX_MODE != 0) begin
            prim = (|py) ? py : px;
            alt  = (|py) ? px : '0;
        end else begin
            prim = (|px) ? px : py;
            alt  = (|px) ? py : '0;
        end
        if (!(|prim)) prim[P_L] = 1'b1;
        sel    = prim;
        sel_ok = 1'b1;
`ifdef FAULT_DETOUR_EN
        if (!prim[P_L] && (|(prim & fault_mask_i))) begin
            if ((|alt) && !(|(alt & fault_mask_i))) begin
                sel = alt;
            end else begin
                sel    = '0;
                sel_ok = 1'b0;
            end
        end
`endif
    end

`ifndef FAULT_DETOUR_EN
    logic unused_fault;
    assign unused_fault = ^fault_mask_i;
`endif

    // While waiting, follow a changed detour choice; keep the old one if none.
    assign wait_port_d = sel_ok ? sel : cand_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            dest_q        <= '0;
            cand_q        <= '0;
            cnt_q         <= '0;
            out_port_q    <= '0;
            route_valid_q <= 1'b0;
            route_fail_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            route_fail_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        dest_q  <= dest_i;
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
                    end
                end
                S_CALC: begin
                    cand_q <= sel;
                    if (!sel_ok) begin
                        route_fail_q <= 1'b1;
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                    end else if (!(|(port_busy_i & sel))) begin
                        out_port_q    <= sel;
                        route_valid_q <= 1'b1;
                        state_q       <= S_GRANT;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cand_q <= wait_port_d;
                    if (!(|(port_busy_i & wait_port_d))) begin
                        out_port_q    <= wait_port_d;
                        route_valid_q <= 1'b1;
                        state_q       <= S_GRANT;
                    end else if (cnt_q == CNT_LAST) begin
                        route_fail_q <= 1'b1;
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GRANT: begin
                    if (ack_i) begin
                        out_port_q    <= '0;
                        route_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_port_o    = out_port_q;
    assign route_valid_o = route_valid_q;
    assign route_fail_o  = route_fail_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_route_compute_unit.sv
// Bench for route_compute_unit: two instances (XY and YX order) share every
// input; a transaction-level model predicts both each cycle, and directed
// scenarios pin latencies and ports with literal values.
module tb_route_compute_unit;
    localparam int          TO = 255;
    localparam logic [15:0] LA = 16'h0101;
`ifdef FAULT_DETOUR_EN
    localparam bit DETOUR = 1'b1;
`else
    localparam bit DETOUR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, req, ack;
    logic [15:0]     dest;
    logic [4:0]      pbusy, fmask;
    logic [1:0][4:0] op;
    logic [1:0]      rv, rf, bz;

    always #5 clk = ~clk;

    route_compute_unit #(.ADDR_W(16), .COORD_W(8), .NPORT(5), .LOCAL_ADDR(LA),
                         .YX_MODE(0), .TIMEOUT(TO)) u0 (
        .clock_i(clk), .reset_i(rst), .req_i(req), .dest_i(dest),
        .port_busy_i(pbusy), .fault_mask_i(fmask), .ack_i(ack),
        .out_port_o(op[0]), .route_valid_o(rv[0]), .route_fail_o(rf[0]), .busy_o(bz[0]));

    route_compute_unit #(.ADDR_W(16), .COORD_W(8), .NPORT(5), .LOCAL_ADDR(LA),
                         .YX_MODE(1), .TIMEOUT(TO)) u1 (
        .clock_i(clk), .reset_i(rst), .req_i(req), .dest_i(dest),
        .port_busy_i(pbusy), .fault_mask_i(fmask), .ack_i(ack),
        .out_port_o(op[1]), .route_valid_o(rv[1]), .route_fail_o(rf[1]), .busy_o(bz[1]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Routing rule: productive port per axis, primary axis by mode, optional detour.
    function automatic logic [4:0] ref_route(input logic [15:0] d, input int yx,
                                             input logic [4:0] flt, output bit ok);
        int dx, dy, lx, ly;
        logic [4:0] xp, yp, first, second;
        dx = int'(d[15:8]); dy = int'(d[7:0]);
        lx = int'(LA[15:8]); ly = int'(LA[7:0]);
        xp = (dx > lx) ? 5'b00001 : (dx < lx) ? 5'b00010 : 5'b00000;
        yp = (dy > ly) ? 5'b00100 : (dy < ly) ? 5'b01000 : 5'b00000;
        ok = 1'b1;
        if (xp == 5'd0 && yp == 5'd0) return 5'b10000;
        if (yx != 0) first = (yp != 5'd0) ? yp : xp;
        else         first = (xp != 5'd0) ? xp : yp;
        second = (first == xp) ? yp : xp;
        if (DETOUR && (first & flt) != 5'd0) begin
            if (second != 5'd0 && (second & flt) == 5'd0) return second;
            ok = 1'b0;
            return 5'd0;
        end
        return first;
    endfunction

    // Model: phase 0 idle, 1 header latched, 2 waiting, 3 granted.
    int         ms[2];
    int         mw[2];
    logic [15:0] md[2];
    logic [4:0]  mp[2];
    bit          mf[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ms[m] = 0; mw[m] = 0; md[m] = '0; mp[m] = '0; mf[m] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit ok;
        logic [4:0] p;
        for (int m = 0; m < 2; m++) begin
            mf[m] = 1'b0;
            case (ms[m])
                0: if (req) begin md[m] = dest; ms[m] = 1; end
                1: begin
                    p = ref_route(md[m], m, fmask, ok);
                    if (!ok) begin mf[m] = 1'b1; ms[m] = 0; end
                    else begin
                        mp[m] = p;
                        if ((pbusy & p) == 5'd0) ms[m] = 3;
                        else begin ms[m] = 2; mw[m] = 0; end
                    end
                end
                2: begin
                    p = ref_route(md[m], m, fmask, ok);
                    if (ok) mp[m] = p;
                    if ((pbusy & mp[m]) == 5'd0) ms[m] = 3;
                    else begin
                        mw[m]++;
                        if (mw[m] == TO) begin mf[m] = 1'b1; ms[m] = 0; end
                    end
                end
                default: if (ack) ms[m] = 0;
            endcase
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int m = 0; m < 2; m++) begin
                    chk($sformatf("cyc_valid%0d", m), 32'(rv[m]), 32'(ms[m] == 3));
                    chk($sformatf("cyc_port%0d", m), 32'(op[m]), 32'((ms[m] == 3) ? mp[m] : 5'd0));
                    chk($sformatf("cyc_fail%0d", m), 32'(rf[m]), 32'(mf[m]));
                    chk($sformatf("cyc_busy%0d", m), 32'(bz[m]), 32'(ms[m] != 0));
                end
            end
        end
    end

    // Present a header; count edges until u0 grants or fails.
    task automatic run_req(input logic [15:0] d, input int rel_at, input bit hold,
                           input int max, output int n);
        @(negedge clk);
        req = 1'b1; dest = d; n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1 && !hold) req = 1'b0;
            if (n == rel_at) pbusy = 5'd0;
        end while (!rv[0] && !rf[0] && n < max);
        chk("wait_bound", 32'(rv[0] | rf[0]), 32'd1);
    endtask

    task automatic do_ack();
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        chk("ack_idle", 32'(bz[0]), 32'd0);
    endtask

    task automatic chk_zero(input string nm);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s_valid%0d", nm, m), 32'(rv[m]), 32'd0);
            chk($sformatf("%s_port%0d", nm, m), 32'(op[m]), 32'd0);
            chk($sformatf("%s_fail%0d", nm, m), 32'(rf[m]), 32'd0);
            chk($sformatf("%s_busy%0d", nm, m), 32'(bz[m]), 32'd0);
        end
    endtask

    initial begin
        int n;
        bit ok;
        logic [4:0] r;
        rst = 1'b1; req = 1'b0; ack = 1'b0; dest = '0; pbusy = '0; fmask = '0;

        // Model pins.
        r = ref_route(16'h0301, 0, 5'd0, ok); chk("pin_east", 32'(r), 32'h01);
        r = ref_route(16'h0100, 0, 5'd0, ok); chk("pin_south", 32'(r), 32'h08);
        r = ref_route(16'h0003, 1, 5'd0, ok); chk("pin_yx_north", 32'(r), 32'h04);
        r = ref_route(16'h0003, 0, 5'd0, ok); chk("pin_xy_west", 32'(r), 32'h02);

        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: east, minimum latency.
        run_req(16'h0301, 0, 1'b0, 20, n);
        chk("t1_lat", 32'(n), 32'd2);
        chk("t1_port", 32'(op[0]), 32'h01);
        do_ack();

        // ack outside GRANT is ignored.
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;

        // 2: local, south.
        run_req(16'h0101, 0, 1'b0, 20, n);
        chk("t2_local", 32'(op[0]), 32'h10);
        do_ack();
        run_req(16'h0100, 0, 1'b0, 20, n);
        chk("t2_south", 32'(op[0]), 32'h08);
        do_ack();

        // 3: XY vs YX.
        run_req(16'h0003, 0, 1'b0, 20, n);
        chk("t3_xy_west", 32'(op[0]), 32'h02);
        chk("t3_yx_north", 32'(op[1]), 32'h04);
        do_ack();

        // 4: east busy through 10 wait-relevant edges, then timeout.
        @(negedge clk); pbusy = 5'b00001;
        run_req(16'h0301, 11, 1'b0, 40, n);
        chk("t4_wait_lat", 32'(n), 32'd12);
        chk("t4_port", 32'(op[0]), 32'h01);
        do_ack();
        @(negedge clk); pbusy = 5'b00001;
        run_req(16'h0301, -1, 1'b0, TO + 40, n);
        chk("t4_fail_lat", 32'(n), 32'(TO + 2));
        chk("t4_fail_pulse", 32'(rf[0]), 32'd1);
        chk("t4_fail_idle", 32'(bz[0]), 32'd0);
        @(posedge clk); #1;
        chk("t4_fail_once", 32'(rf[0]), 32'd0);
        @(negedge clk); pbusy = 5'd0;

`ifdef FAULT_DETOUR_EN
        // 5: detour around faulty east, and no usable port.
        fmask = 5'b00001;
        run_req(16'h0303, 0, 1'b0, 20, n);
        chk("t5_detour", 32'(op[0]), 32'h04);
        do_ack();
        run_req(16'h0301, 0, 1'b0, 20, n);
        chk("t5_fail_lat", 32'(n), 32'd2);
        chk("t5_fail", 32'(rf[0]), 32'd1);
        @(negedge clk); fmask = 5'd0;
`endif

        // 6: reset in WAIT and in GRANT.
        @(negedge clk); pbusy = 5'b00001; req = 1'b1; dest = 16'h0301;
        @(negedge clk); req = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_in_wait", 32'(bz[0]), 32'd1);
        rst = 1'b1; #1;
        chk_zero("t6_rst_wait");
        @(negedge clk); rst = 1'b0; pbusy = 5'd0;
        run_req(16'h0301, 0, 1'b0, 20, n);
        @(negedge clk); rst = 1'b1; #1;
        chk_zero("t6_rst_grant");
        @(negedge clk); rst = 1'b0;

        // req held through GRANT: accepted only after return to IDLE.
        run_req(16'h0003, 0, 1'b1, 20, n);
        chk("t6_hold_lat", 32'(n), 32'd2);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_hold_valid", 32'(rv[0]), 32'd1);
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1;
        chk("t6_hold_idle", 32'(bz[0]), 32'd0);
        @(negedge clk); ack = 1'b0;
        @(posedge clk); #1;
        chk("t6_hold_reaccept", 32'(bz[0]), 32'd1);
        req = 1'b0;
        @(posedge clk); #1;
        chk("t6_hold_regrant", 32'(rv[0]), 32'd1);
        do_ack();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
